param_updown_counter: RTL and testbench
=======================================

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clock and reset.
REQ-002 Parameter WIDTH, default 32: counter width in bits.
REQ-003 Parameter STEP_W, default 8: width of the step input.
REQ-004 Parameter LIMIT_LO, default 0: lower count bound; LIMIT_LO <= LIMIT_HI SHALL hold.
REQ-005 Parameter LIMIT_HI, default 2^WIDTH-1: upper count bound.
REQ-006 clock  input  1  rising-edge clock.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 en  input  1  count enable.
REQ-009 dir  input  1  direction: 0 counts up, 1 counts down.
REQ-010 step  input  STEP_W  magnitude added or subtracted per enabled cycle.
REQ-011 sat_mode  input  1  bound behaviour: 1 saturates at the bound, 0 wraps.
REQ-012 load  input  1  synchronous load request.
REQ-013 load_value  input  WIDTH  value to load.
REQ-014 clear_flags  input  1  clears the sticky overflow and underflow flags.
REQ-015 value  output  WIDTH  registered count.
REQ-016 at_max  output  1  combinational, value == LIMIT_HI.
REQ-017 at_min  output  1  combinational, value == LIMIT_LO.
REQ-018 overflow  output  1  sticky flag: an up count crossed LIMIT_HI.
REQ-019 underflow  output  1  sticky flag: a down count crossed LIMIT_LO.
REQ-020 wrap_pulse  output  1  registered, high for exactly one cycle after a wrap occurs.

Function
REQ-021 Per-edge priority SHALL be: reset > load > en > hold.
REQ-022 On load, value SHALL become load_value clamped to [LIMIT_LO, LIMIT_HI]; no count occurs that cycle and the flags SHALL NOT change.
REQ-023 RANGE = LIMIT_HI - LIMIT_LO + 1, computed at WIDTH+1 bits.
REQ-024 The effective step SHALL be min(step, RANGE); all arithmetic SHALL use WIDTH+2 bits with no intermediate truncation.
REQ-025 When en=1 and step=0, value, the flags and wrap_pulse SHALL be unchanged/low.
REQ-026 Up count with no crossing: value <= value + effective step.
REQ-027 Up count crossing LIMIT_HI, sat_mode=1: value <= LIMIT_HI and overflow is set.
REQ-028 Up count crossing LIMIT_HI, sat_mode=0: value <= value + effective step - RANGE; overflow is set and wrap_pulse=1 next cycle.
REQ-029 Down count below LIMIT_LO follows the mirrored rules: saturate to LIMIT_LO, or wrap with value <= value - effective step + RANGE. Underflow is set; wrap_pulse=1 on a wrap.
REQ-030 Landing exactly on a bound SHALL NOT be a crossing and SHALL set no flag.
REQ-031 In saturate mode, a count that is already at the bound and pushes outward SHALL re-set the flag and hold value.
REQ-032 clear_flags SHALL clear both sticky flags next edge; a crossing in the same cycle SHALL win, leaving its flag set.
REQ-033 Latency: every value and flag update is visible one edge after the request; at_max and at_min follow value combinationally.
REQ-034 When LIMIT_LO == LIMIT_HI, value SHALL stay constant; any nonzero step is a crossing.

Reset
REQ-035 While reset=1 at an edge: value <= LIMIT_LO; overflow, underflow and wrap_pulse <= 0, regardless of load or en.
REQ-036 Reset asserted mid-count SHALL take effect at the next edge, with no partial update.

Verification (WIDTH=8, STEP_W=8, LIMIT_LO=10, LIMIT_HI=20)
REQ-037 Reset held 1 cycle -> value=10, at_min=1, at_max=0, all flags 0.
REQ-038 value=19, sat_mode=0, dir=0, step=3, en=1 -> value=11, overflow=1, wrap_pulse high for exactly 1 cycle.
REQ-039 value=12, sat_mode=1, dir=1, step=5 -> value=10, underflow=1, at_min=1; a second identical cycle -> value stays 10.
REQ-040 load=1, en=1, load_value=30 -> value=20, at_max=1, flags unchanged; load_value=3 -> value=10.
REQ-041 overflow=1; clear_flags=1 with 20, up, step 1, wrap mode in the same cycle -> value=10, overflow stays 1; the next cycle with clear_flags only -> overflow=0.
REQ-042 step=200 (> RANGE=11) from 15, up, wrap mode -> value=15, overflow=1; reset with load=1 -> value=10.

Source files
------------

// File: rtl/param_updown_counter.sv
// Parameterised up/down counter bounded to [LIMIT_LO, LIMIT_HI].
// Supports saturate or wrap at the bounds, a clamped load, and sticky overflow/underflow flags.
module param_updown_counter #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      STEP_W   = 8,
  parameter logic [WIDTH-1:0] LIMIT_LO = '0,
  parameter logic [WIDTH-1:0] LIMIT_HI = '1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic              dir,
  input  logic [STEP_W-1:0] step,
  input  logic              sat_mode,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_value,
  input  logic              clear_flags,
  output logic [WIDTH-1:0]  value,
  output logic              at_max,
  output logic              at_min,
  output logic              overflow,
  output logic              underflow,
  output logic              wrap_pulse
);

  // Arithmetic width: two guard bits so value + step and value + RANGE never truncate.
  localparam int unsigned AW = WIDTH + 2;
  localparam int unsigned CW = (STEP_W + 1 > AW) ? STEP_W + 1 : AW;

  localparam logic [AW-1:0] LO_A    = AW'(LIMIT_LO);
  localparam logic [AW-1:0] HI_A    = AW'(LIMIT_HI);
  localparam logic [AW-1:0] RANGE_A = HI_A - LO_A + AW'(1);

  logic [WIDTH-1:0] r_value;
  logic             r_overflow;
  logic             r_underflow;
  logic             r_wrap;

  logic [CW-1:0]    w_step_c;
  logic [CW-1:0]    w_range_c;
  logic [AW-1:0]    w_eff;
  logic [AW-1:0]    w_val_a;
  logic [AW-1:0]    w_sum;
  logic [AW-1:0]    w_lo_plus_eff;
  logic             w_up_cross;
  logic             w_dn_cross;

  logic             w_below_lo;
  logic             w_above_hi;
  logic [WIDTH-1:0] w_load_clamped;

  logic [WIDTH-1:0] w_value_nxt;
  logic             w_overflow_nxt;
  logic             w_underflow_nxt;
  logic             w_wrap_nxt;

  // Effective step is capped at RANGE; the compare is done wide enough for either operand.
  assign w_step_c  = CW'(step);
  assign w_range_c = CW'(RANGE_A);
  assign w_eff     = (w_step_c < w_range_c) ? AW'(w_step_c) : AW'(w_range_c);

  assign w_val_a       = AW'(r_value);
  assign w_sum         = w_val_a + w_eff;
  assign w_lo_plus_eff = LO_A + w_eff;
  assign w_up_cross    = (w_sum > HI_A);
  assign w_dn_cross    = (w_val_a < w_lo_plus_eff);

  // Borrow-out of a one-bit-wider subtraction gives the out-of-range tests for the load clamp.
  assign w_below_lo = 1'(({1'b0, load_value} - {1'b0, LIMIT_LO}) >> WIDTH);
  assign w_above_hi = 1'(({1'b0, LIMIT_HI} - {1'b0, load_value}) >> WIDTH);
  assign w_load_clamped = w_below_lo ? LIMIT_LO :
                          w_above_hi ? LIMIT_HI : load_value;

  always_comb begin
    w_value_nxt     = r_value;
    w_overflow_nxt  = r_overflow;
    w_underflow_nxt = r_underflow;
    w_wrap_nxt      = 1'b0;

    if (load) begin
      w_value_nxt = w_load_clamped;
    end else begin
      if (clear_flags) begin
        w_overflow_nxt  = 1'b0;
        w_underflow_nxt = 1'b0;
      end
      if (en) begin
        if (!dir) begin
          if (w_up_cross) begin
            w_overflow_nxt = 1'b1;
            if (sat_mode) begin
              w_value_nxt = LIMIT_HI;
            end else begin
              w_value_nxt = WIDTH'(w_sum - RANGE_A);
              w_wrap_nxt  = 1'b1;
            end
          end else begin
            w_value_nxt = WIDTH'(w_sum);
          end
        end else begin
          if (w_dn_cross) begin
            w_underflow_nxt = 1'b1;
            if (sat_mode) begin
              w_value_nxt = LIMIT_LO;
            end else begin
              w_value_nxt = WIDTH'(w_val_a + RANGE_A - w_eff);
              w_wrap_nxt  = 1'b1;
            end
          end else begin
            w_value_nxt = WIDTH'(w_val_a - w_eff);
          end
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_value     <= LIMIT_LO;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_value     <= w_value_nxt;
      r_overflow  <= w_overflow_nxt;
      r_underflow <= w_underflow_nxt;
      r_wrap      <= w_wrap_nxt;
    end
  end

  assign value      = r_value;
  assign at_max     = (r_value == LIMIT_HI);
  assign at_min     = (r_value == LIMIT_LO);
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;
  assign wrap_pulse = r_wrap;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed, table-driven bench for param_updown_counter with bounds [10,20],
// plus a second instance with a single-value range [7,7].
module tb_param_updown_counter;

  logic       clock;
  logic       reset;
  logic       en;
  logic       dir;
  logic [7:0] step;
  logic       sat_mode;
  logic       load;
  logic [7:0] load_value;
  logic       clear_flags;

  logic [7:0] value;
  logic       at_max, at_min, overflow, underflow, wrap_pulse;

  logic [7:0] pt_value;
  logic       pt_at_max, pt_at_min, pt_overflow, pt_underflow, pt_wrap_pulse;

  int checks = 0;
  int errors = 0;

  param_updown_counter #(
    .WIDTH(8), .STEP_W(8), .LIMIT_LO(8'd10), .LIMIT_HI(8'd20)
  ) dut (
    .clock(clock), .reset(reset), .en(en), .dir(dir), .step(step),
    .sat_mode(sat_mode), .load(load), .load_value(load_value),
    .clear_flags(clear_flags), .value(value), .at_max(at_max),
    .at_min(at_min), .overflow(overflow), .underflow(underflow),
    .wrap_pulse(wrap_pulse)
  );

  param_updown_counter #(
    .WIDTH(8), .STEP_W(8), .LIMIT_LO(8'd7), .LIMIT_HI(8'd7)
  ) dut_pt (
    .clock(clock), .reset(reset), .en(en), .dir(dir), .step(step),
    .sat_mode(sat_mode), .load(load), .load_value(load_value),
    .clear_flags(clear_flags), .value(pt_value), .at_max(pt_at_max),
    .at_min(pt_at_min), .overflow(pt_overflow), .underflow(pt_underflow),
    .wrap_pulse(pt_wrap_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       ld;
    logic [7:0] ldv;
    logic       en;
    logic       dir;
    logic [7:0] step;
    logic       sat;
    logic       clr;
    logic [7:0] e_val;
    logic       e_ovf;
    logic       e_udf;
    logic       e_wrap;
    logic       e_max;
    logic       e_min;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic rst, input logic ld, input logic [7:0] ldv, input logic e,
    input logic d, input logic [7:0] s, input logic sat, input logic clr,
    input logic [7:0] ev, input logic eo, input logic eu, input logic ew,
    input logic emx, input logic emn);
    vec_t v;
    v.rst = rst; v.ld = ld; v.ldv = ldv; v.en = e; v.dir = d; v.step = s;
    v.sat = sat; v.clr = clr; v.e_val = ev; v.e_ovf = eo; v.e_udf = eu;
    v.e_wrap = ew; v.e_max = emx; v.e_min = emn;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ld, input logic [7:0] ldv,
                       input logic e, input logic d, input logic [7:0] s,
                       input logic sat, input logic clr);
    reset = rst; load = ld; load_value = ldv; en = e; dir = d; step = s;
    sat_mode = sat; clear_flags = clr;
    @(posedge clock);
    #1;
  endtask

  task automatic check_main(input string tag, input logic [7:0] ev, input logic eo,
                            input logic eu, input logic ew, input logic emx, input logic emn);
    check({tag, " value"},      32'(value),      32'(ev));
    check({tag, " overflow"},   32'(overflow),   32'(eo));
    check({tag, " underflow"},  32'(underflow),  32'(eu));
    check({tag, " wrap_pulse"}, 32'(wrap_pulse), 32'(ew));
    check({tag, " at_max"},     32'(at_max),     32'(emx));
    check({tag, " at_min"},     32'(at_min),     32'(emn));
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; load_value = '0; en = 1'b0; dir = 1'b0;
    step = '0; sat_mode = 1'b0; clear_flags = 1'b0;

    //                rst ld ldv  en dir step sat clr | val ovf udf wrp max min
    vq.push_back(mk(1, 0,  0, 0, 0,   0, 0, 0,  10, 0, 0, 0, 0, 1)); // reset state
    vq.push_back(mk(0, 1, 19, 0, 0,   0, 0, 0,  19, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0,  0, 1, 0,   3, 0, 0,  11, 1, 0, 1, 0, 0)); // up wrap
    vq.push_back(mk(0, 0,  0, 0, 0,   0, 0, 0,  11, 1, 0, 0, 0, 0)); // pulse gone
    vq.push_back(mk(0, 0,  0, 0, 0,   0, 0, 1,  11, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 12, 0, 0,   0, 0, 0,  12, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0,  0, 1, 1,   5, 1, 0,  10, 0, 1, 0, 0, 1)); // down sat
    vq.push_back(mk(0, 0,  0, 1, 1,   5, 1, 0,  10, 0, 1, 0, 0, 1)); // push at bound
    vq.push_back(mk(0, 1, 30, 1, 0,   1, 0, 0,  20, 0, 1, 0, 1, 0)); // load clamp hi
    vq.push_back(mk(0, 1,  3, 1, 0,   1, 0, 0,  10, 0, 1, 0, 0, 1)); // load clamp lo
    vq.push_back(mk(0, 0,  0, 0, 0,   0, 0, 1,  10, 0, 0, 0, 0, 1));
    vq.push_back(mk(0, 1, 20, 0, 0,   0, 0, 0,  20, 0, 0, 0, 1, 0));
    vq.push_back(mk(0, 0,  0, 1, 0,   1, 0, 1,  10, 1, 0, 1, 0, 1)); // crossing beats clear
    vq.push_back(mk(0, 0,  0, 0, 0,   0, 0, 1,  10, 0, 0, 0, 0, 1));
    vq.push_back(mk(0, 1, 15, 0, 0,   0, 0, 0,  15, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0,  0, 1, 0, 200, 0, 0,  15, 1, 0, 1, 0, 0)); // step capped to RANGE
    vq.push_back(mk(1, 1, 18, 1, 0,   3, 0, 0,  10, 0, 0, 0, 0, 1)); // reset beats load
    vq.push_back(mk(0, 1, 17, 1, 0,   3, 0, 0,  17, 0, 0, 0, 0, 0)); // load beats en
    vq.push_back(mk(0, 0,  0, 1, 0,   3, 0, 0,  20, 0, 0, 0, 1, 0)); // land on HI
    vq.push_back(mk(0, 0,  0, 1, 0,   0, 0, 0,  20, 0, 0, 0, 1, 0)); // step 0
    vq.push_back(mk(0, 0,  0, 1, 1,  10, 0, 0,  10, 0, 0, 0, 0, 1)); // land on LO
    vq.push_back(mk(0, 0,  0, 1, 1,   1, 0, 0,  20, 0, 1, 1, 1, 0)); // down wrap
    vq.push_back(mk(0, 0,  0, 1, 0,   1, 1, 0,  20, 1, 1, 0, 1, 0)); // up sat at HI
    vq.push_back(mk(0, 0,  0, 1, 1,   4, 1, 0,  16, 1, 1, 0, 0, 0));
    vq.push_back(mk(0, 0,  0, 0, 1,   4, 1, 0,  16, 1, 1, 0, 0, 0)); // hold
    vq.push_back(mk(0, 1, 13, 0, 0,   0, 0, 1,  13, 1, 1, 0, 0, 0)); // load keeps flags
    vq.push_back(mk(0, 0,  0, 1, 1,   3, 1, 1,  10, 0, 0, 0, 0, 1));

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].ld, vq[i].ldv, vq[i].en, vq[i].dir, vq[i].step,
            vq[i].sat, vq[i].clr);
      check_main($sformatf("vec%0d", i), vq[i].e_val, vq[i].e_ovf, vq[i].e_udf,
                 vq[i].e_wrap, vq[i].e_max, vq[i].e_min);
    end

    // Multi-cycle count interrupted by reset: no partial update.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      drive(0, 0, 0, 1, 0, 2, 1, 0);
      check($sformatf("run%0d value", k), 32'(value), 32'(10 + 2 * k));
    end
    drive(1, 0, 0, 1, 0, 2, 1, 0);
    check_main("midreset", 10, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_main("postreset", 10, 0, 0, 0, 0, 1);

    // Single-value range: value never moves, any nonzero step crosses.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check("pt reset value", 32'(pt_value), 32'd7);
    check("pt at_max", 32'(pt_at_max), 32'd1);
    check("pt at_min", 32'(pt_at_min), 32'd1);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    check("pt step0 overflow", 32'(pt_overflow), 32'd0);
    check("pt step0 wrap", 32'(pt_wrap_pulse), 32'd0);
    drive(0, 0, 0, 1, 0, 3, 0, 0);
    check("pt up value", 32'(pt_value), 32'd7);
    check("pt up overflow", 32'(pt_overflow), 32'd1);
    check("pt up wrap", 32'(pt_wrap_pulse), 32'd1);
    drive(0, 0, 0, 1, 1, 1, 1, 0);
    check("pt dn value", 32'(pt_value), 32'd7);
    check("pt dn underflow", 32'(pt_underflow), 32'd1);
    check("pt dn wrap", 32'(pt_wrap_pulse), 32'd0);
    drive(0, 1, 100, 0, 0, 0, 0, 0);
    check("pt load value", 32'(pt_value), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
